// File: rtl/board_move_engine.sv
// 2048 game-state core: slides and merges the 4x4 board one line per cycle on each
// direction command, spawns a tile from an LFSR and tracks win / game-over.
module board_move_engine #(
   parameter int unsigned WIN_EXP   = 11,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic        clock50,
   input  logic        reset,
   input  logic        cmd_valid,
   input  logic [1:0]  cmd_dir,
   output logic        cmd_ready,
   input  logic        load_en,
   input  logic [63:0] load_board,
   output logic [63:0] board,
   output logic        done,
   output logic        moved,
   output logic        win,
   output logic        game_over
);

   typedef enum logic [3:0] {
      S_INIT0, S_INIT1, S_IDLE, S_LINE0, S_LINE1, S_LINE2, S_LINE3,
      S_EVAL, S_SPAWN, S_DONE, S_OVER
   } state_t;

   state_t      state_q, state_d;
   logic [63:0] board_q, board_d;
   logic [15:0] lfsr_q, lfsr_d;
   logic [1:0]  dir_q, dir_d;
   logic        changed_q, changed_d;
   logic        win_q, win_d;
   logic        game_over_q, game_over_d;
   logic [3:0]  spawn_idx_q, spawn_idx_d;
   logic [3:0]  spawn_val_q, spawn_val_d;
   logic [3:0]  spawn_cnt_q, spawn_cnt_d;

   logic [1:0]  line_sel;
   logic [3:0]  line_idx [4];
   logic [3:0]  line_in  [4];
   logic [3:0]  line_out [4];
   logic [3:0]  compact  [5];
   logic [2:0]  k;
   logic        skip;
   logic [3:0]  merged;
   logic        line_win;
   logic        line_changed;
   logic        has_move;
   logic        spawn_hit;

   // Maps position pos (0 = leading edge of the move) within the selected line
   // to a cell index 4*y+x for the given direction.
   function automatic logic [3:0] cell_index(input logic [1:0] dir, input logic [1:0] line,
                                             input logic [1:0] pos);
      logic [1:0] x;
      logic [1:0] y;
      case (dir)
         2'd0:    begin x = pos;         y = line;        end
         2'd1:    begin x = 2'd3 - pos;  y = line;        end
         2'd2:    begin x = line;        y = pos;         end
         default: begin x = line;        y = 2'd3 - pos;  end
      endcase
      return {y, x};
   endfunction

   // Selects which row/column is processed from the current LINEi state.
   always_comb begin
      line_sel = 2'd0;
      case (state_q)
         S_LINE1: line_sel = 2'd1;
         S_LINE2: line_sel = 2'd2;
         S_LINE3: line_sel = 2'd3;
         default: line_sel = 2'd0;
      endcase
   end

   // Gathers the selected line, compacts it toward e0, merges equal pairs once
   // each, and reports whether the line changed or produced a winning tile.
   // After compaction zeros are trailing, so a non-zero check is enough to stop merging.
   always_comb begin
      for (int p = 0; p < 4; p++) begin
         line_idx[p] = cell_index(dir_q, line_sel, 2'(p));
         line_in[p]  = board_q[{line_idx[p], 2'b00} +: 4];
         line_out[p] = 4'd0;
      end
      for (int p = 0; p < 5; p++)
         compact[p] = 4'd0;
      k = 3'd0;
      for (int p = 0; p < 4; p++) begin
         if (line_in[p] != 4'd0) begin
            compact[k] = line_in[p];
            k = k + 3'd1;
         end
      end
      k        = 3'd0;
      skip     = 1'b0;
      merged   = 4'd0;
      line_win = 1'b0;
      for (int p = 0; p < 4; p++) begin
         if (skip) begin
            skip = 1'b0;
         end else if (compact[p] != 4'd0 && compact[p] == compact[p+1]) begin
            merged = (compact[p] == 4'hF) ? 4'hF : compact[p] + 4'd1;
            line_out[k[1:0]] = merged;
            if (32'(merged) >= WIN_EXP)
               line_win = 1'b1;
            k    = k + 3'd1;
            skip = 1'b1;
         end else if (compact[p] != 4'd0) begin
            line_out[k[1:0]] = compact[p];
            k = k + 3'd1;
         end
      end
      line_changed = 1'b0;
      for (int p = 0; p < 4; p++)
         if (line_out[p] != line_in[p])
            line_changed = 1'b1;
   end

   // Game-over test: any empty cell or any horizontally/vertically adjacent equal pair
   // means a move is still possible.
   always_comb begin
      has_move = 1'b0;
      for (int y = 0; y < 4; y++)
         for (int x = 0; x < 4; x++)
            if (board_q[(4*y+x)*4 +: 4] == 4'd0)
               has_move = 1'b1;
      for (int y = 0; y < 4; y++)
         for (int x = 0; x < 3; x++)
            if (board_q[(4*y+x)*4 +: 4] == board_q[(4*y+x+1)*4 +: 4])
               has_move = 1'b1;
      for (int y = 0; y < 3; y++)
         for (int x = 0; x < 4; x++)
            if (board_q[(4*y+x)*4 +: 4] == board_q[(4*y+x+4)*4 +: 4])
               has_move = 1'b1;
   end

   // Main FSM next-state logic: init spawns, idle handshake/load, line processing,
   // evaluation, spawn search, done pulse and game-over hold.
   always_comb begin
      state_d     = state_q;
      board_d     = board_q;
      lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
      dir_d       = dir_q;
      changed_d   = changed_q;
      win_d       = win_q;
      game_over_d = game_over_q;
      spawn_idx_d = spawn_idx_q;
      spawn_val_d = spawn_val_q;
      spawn_cnt_d = spawn_cnt_q;
      spawn_hit   = (board_q[{spawn_idx_q, 2'b00} +: 4] == 4'd0);

      case (state_q)
         S_INIT0, S_INIT1, S_SPAWN: begin
            if (spawn_hit || spawn_cnt_q == 4'd15) begin
               if (spawn_hit)
                  board_d[{spawn_idx_q, 2'b00} +: 4] = spawn_val_q;
               if (state_q == S_INIT0) begin
                  state_d     = S_INIT1;
                  spawn_idx_d = lfsr_d[3:0];
                  spawn_val_d = (lfsr_d[7:5] == 3'd0) ? 4'd2 : 4'd1;
                  spawn_cnt_d = 4'd0;
               end else if (state_q == S_INIT1) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_DONE;
               end
            end else begin
               spawn_idx_d = spawn_idx_q + 4'd1;
               spawn_cnt_d = spawn_cnt_q + 4'd1;
            end
         end
         S_IDLE: begin
            if (load_en) begin
               board_d     = load_board;
               win_d       = 1'b0;
               game_over_d = 1'b0;
            end else if (cmd_valid) begin
               dir_d     = cmd_dir;
               changed_d = 1'b0;
               state_d   = S_LINE0;
            end
         end
         S_LINE0, S_LINE1, S_LINE2, S_LINE3: begin
            for (int p = 0; p < 4; p++)
               board_d[{line_idx[p], 2'b00} +: 4] = line_out[p];
            changed_d = changed_q | line_changed;
            win_d     = win_q | line_win;
            case (state_q)
               S_LINE0: state_d = S_LINE1;
               S_LINE1: state_d = S_LINE2;
               S_LINE2: state_d = S_LINE3;
               default: state_d = S_EVAL;
            endcase
         end
         S_EVAL: begin
            if (changed_q) begin
               state_d     = S_SPAWN;
               spawn_idx_d = lfsr_d[3:0];
               spawn_val_d = (lfsr_d[7:5] == 3'd0) ? 4'd2 : 4'd1;
               spawn_cnt_d = 4'd0;
            end else begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (!has_move) begin
               game_over_d = 1'b1;
               state_d     = S_OVER;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_OVER: begin
            if (load_en) begin
               board_d     = load_board;
               win_d       = 1'b0;
               game_over_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_INIT0;
      endcase
   end

   // State registers with synchronous active-high reset that wins over everything.
   always_ff @(posedge clock50) begin
      if (reset) begin
         state_q     <= S_INIT0;
         board_q     <= 64'd0;
         lfsr_q      <= LFSR_SEED;
         dir_q       <= 2'd0;
         changed_q   <= 1'b0;
         win_q       <= 1'b0;
         game_over_q <= 1'b0;
         spawn_idx_q <= LFSR_SEED[3:0];
         spawn_val_q <= (LFSR_SEED[7:5] == 3'd0) ? 4'd2 : 4'd1;
         spawn_cnt_q <= 4'd0;
      end else begin
         state_q     <= state_d;
         board_q     <= board_d;
         lfsr_q      <= lfsr_d;
         dir_q       <= dir_d;
         changed_q   <= changed_d;
         win_q       <= win_d;
         game_over_q <= game_over_d;
         spawn_idx_q <= spawn_idx_d;
         spawn_val_q <= spawn_val_d;
         spawn_cnt_q <= spawn_cnt_d;
      end
   end

   assign board     = board_q;
   assign cmd_ready = (state_q == S_IDLE);
   assign done      = (state_q == S_DONE);
   assign moved     = (state_q == S_DONE) && changed_q;
   assign win       = win_q;
   assign game_over = game_over_q;

endmodule

// File: tb/tb_board_move_engine.sv
// Scoreboard bench for board_move_engine: directed moves push expected results,
// a monitor compares them whenever done pulses.
module tb_board_move_engine;

   logic        clock50 = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic [1:0]  cmd_dir;
   logic        cmd_ready;
   logic        load_en;
   logic [63:0] load_board;
   logic [63:0] board;
   logic        done;
   logic        moved;
   logic        win;
   logic        game_over;

   localparam logic [63:0] CHECKER = 64'h1212_2121_1212_2121;

   typedef struct {
      logic [63:0] board;
      bit          checkBoard;
      bit          spawn;
      bit          checkMoved;
      bit          moved;
      bit          win;
      int          latency;
   } exp_t;

   exp_t expQ[$];
   exp_t monExp;
   int   assertCount = 0;
   int   failCount = 0;
   int   cyc = 0;
   int   hsCyc = 0;
   int   doneCnt = 0;
   int   monBad;
   int   monSpawn;

   // 50 MHz system clock
   always #10 clock50 = ~clock50;

   board_move_engine #(.WIN_EXP(11), .LFSR_SEED(16'hACE1)) dut (
      .clock50(clock50), .reset(reset), .cmd_valid(cmd_valid), .cmd_dir(cmd_dir),
      .cmd_ready(cmd_ready), .load_en(load_en), .load_board(load_board), .board(board),
      .done(done), .moved(moved), .win(win), .game_over(game_over)
   );

   always @(posedge clock50) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
      assertCount++;
      if (act !== req) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   // Cells that differ from the expectation must be previously-empty cells now holding 1 or 2
   function automatic void cmpBoard(input logic [63:0] act, input logic [63:0] req,
                                    output int bad, output int spawned);
      logic [3:0] a;
      logic [3:0] r;
      bad = 0;
      spawned = 0;
      for (int c = 0; c < 16; c++) begin
         a = act[c*4 +: 4];
         r = req[c*4 +: 4];
         if (a != r) begin
            if (r == 4'd0 && (a == 4'd1 || a == 4'd2)) spawned++;
            else bad++;
         end
      end
   endfunction

   function automatic exp_t mkExp(input logic [63:0] b, input bit cb, input bit sp, input bit cm,
                                  input bit mv, input bit w, input int lat);
      exp_t e;
      e.board = b; e.checkBoard = cb; e.spawn = sp; e.checkMoved = cm;
      e.moved = mv; e.win = w; e.latency = lat;
      return e;
   endfunction

   // Monitor: every done pulse consumes one expected response
   always @(negedge clock50) begin
      if (!reset && done) begin
         doneCnt++;
         if (expQ.size() == 0) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL unexpected_done: got done=1 with no command outstanding, required done=0");
         end else begin
            monExp = expQ.pop_front();
            if (monExp.checkBoard) begin
               cmpBoard(board, monExp.board, monBad, monSpawn);
               checkOutput("done_board_cells", 64'(monBad), 64'd0);
               checkOutput("done_spawn_count", 64'(monSpawn), monExp.spawn ? 64'd1 : 64'd0);
            end
            if (monExp.checkMoved) checkOutput("done_moved", 64'(moved), 64'(monExp.moved));
            checkOutput("done_win", 64'(win), 64'(monExp.win));
            if (monExp.latency != 0)
               checkOutput("done_latency", 64'(cyc - hsCyc + 1), 64'(monExp.latency));
         end
      end
   end

   task automatic waitReady(input int budget, input string name);
      int i = 0;
      @(negedge clock50);
      while (!cmd_ready && i < budget) begin
         @(negedge clock50);
         i++;
      end
      checkOutput(name, 64'(cmd_ready), 64'd1);
   endtask

   task automatic loadBoard(input logic [63:0] v);
      load_en = 1'b1;
      load_board = v;
      @(posedge clock50);
      #1;
      load_en = 1'b0;
      @(negedge clock50);
      checkOutput("load_board", board, v);
   endtask

   task automatic applyStimulus(input logic [1:0] dir, input exp_t e);
      waitReady(40, "ready_before_cmd");
      expQ.push_back(e);
      cmd_valid = 1'b1;
      cmd_dir = dir;
      @(posedge clock50);
      #1;
      hsCyc = cyc;
      cmd_valid = 1'b0;
   endtask

   task automatic waitDone(input int prev);
      int i = 0;
      while (doneCnt == prev && i < 60) begin
         @(negedge clock50);
         #2;
         i++;
      end
      checkOutput("done_seen", 64'(doneCnt != prev), 64'd1);
   endtask

   task automatic checkInitTiles();
      int nz = 0;
      int badv = 0;
      for (int c = 0; c < 16; c++) begin
         if (board[c*4 +: 4] != 4'd0) begin
            nz++;
            if (board[c*4 +: 4] != 4'd1 && board[c*4 +: 4] != 4'd2) badv++;
         end
      end
      checkOutput("init_tile_count", 64'(nz), 64'd2);
      checkOutput("init_tile_values", 64'(badv), 64'd0);
   endtask

   // Directed sequence
   initial begin
      int n;
      reset = 1'b1; cmd_valid = 1'b0; cmd_dir = 2'd0; load_en = 1'b0; load_board = 64'd0;
      @(negedge clock50);
      checkOutput("reset_board", board, 64'd0);
      checkOutput("reset_ready", 64'(cmd_ready), 64'd0);
      checkOutput("reset_done", 64'(done), 64'd0);
      checkOutput("reset_win", 64'(win), 64'd0);
      repeat (2) @(negedge clock50);
      reset = 1'b0;

      $display("[TB] test 1: initial spawns");
      waitReady(34, "init_ready");
      checkInitTiles();
      checkOutput("init_win", 64'(win), 64'd0);
      checkOutput("init_game_over", 64'(game_over), 64'd0);

      $display("[TB] test 2: merge pairs left");
      loadBoard(64'h2211);
      n = doneCnt;
      applyStimulus(2'd0, mkExp(64'h0032, 1, 1, 1, 1, 0, 0));
      waitDone(n);

      $display("[TB] test 3: four equal and right move");
      waitReady(5, "ready_t3a");
      loadBoard(64'h1111);
      n = doneCnt;
      applyStimulus(2'd0, mkExp(64'h0022, 1, 1, 1, 1, 0, 0));
      waitDone(n);
      waitReady(5, "ready_t3b");
      loadBoard(64'h0111);
      n = doneCnt;
      applyStimulus(2'd1, mkExp(64'h2100, 1, 1, 1, 1, 0, 0));
      waitDone(n);

      $display("[TB] test 4: no-change move and busy command");
      waitReady(5, "ready_t4");
      loadBoard(64'h4321);
      n = doneCnt;
      applyStimulus(2'd0, mkExp(64'h4321, 1, 0, 1, 0, 0, 6));
      repeat (2) @(negedge clock50);
      cmd_valid = 1'b1;
      cmd_dir = 2'd3;
      @(posedge clock50);
      #1;
      cmd_valid = 1'b0;
      waitDone(n);
      @(negedge clock50);
      checkOutput("ready_after_nochange", 64'(cmd_ready), 64'd1);
      repeat (12) @(negedge clock50);
      checkOutput("busy_cmd_ignored", board, 64'h4321);

      $display("[TB] test 5: win");
      waitReady(5, "ready_t5");
      loadBoard(64'h0000_0000_000A_000A);
      n = doneCnt;
      applyStimulus(2'd2, mkExp(64'h000B, 1, 1, 1, 1, 1, 0));
      waitDone(n);
      n = doneCnt;
      applyStimulus(2'd3, mkExp(64'd0, 0, 0, 0, 0, 1, 0));
      waitDone(n);
      waitReady(5, "ready_t5b");
      checkOutput("win_sticky", 64'(win), 64'd1);
      loadBoard(64'h4321);
      checkOutput("win_cleared_by_load", 64'(win), 64'd0);

      $display("[TB] test 6: game over and mid-command reset");
      waitReady(5, "ready_t6");
      loadBoard(CHECKER);
      n = doneCnt;
      applyStimulus(2'd0, mkExp(CHECKER, 1, 0, 1, 0, 0, 6));
      waitDone(n);
      @(negedge clock50);
      checkOutput("game_over_set", 64'(game_over), 64'd1);
      checkOutput("over_not_ready", 64'(cmd_ready), 64'd0);
      repeat (5) @(negedge clock50);
      checkOutput("over_stays_not_ready", 64'(cmd_ready), 64'd0);
      loadBoard(64'h2211);
      checkOutput("load_from_over_ready", 64'(cmd_ready), 64'd1);
      checkOutput("load_from_over_go", 64'(game_over), 64'd0);
      applyStimulus(2'd0, mkExp(64'h0032, 1, 1, 1, 1, 0, 0));
      repeat (3) @(negedge clock50);
      reset = 1'b1;
      @(negedge clock50);
      checkOutput("midcmd_reset_board", board, 64'd0);
      checkOutput("midcmd_reset_ready", 64'(cmd_ready), 64'd0);
      expQ.delete();
      reset = 1'b0;
      waitReady(34, "reinit_ready");
      checkInitTiles();

      repeat (10) @(negedge clock50);
      checkOutput("scoreboard_drained", 64'(expQ.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

   // Global time bound
   initial begin
      #2000000;
      failCount++;
      $display("[TB] FAIL watchdog: got simulation still running, required completion");
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
